m2v_coef_scanbuf: RTL

- Upstream neighbour of the IDCT stage.
- Accepts dequantized run/level events from the VLD/IQ stage.
- Places them into a 64-entry block in raster order using the inverse zigzag or alternate scan.
- Serves coefficients to the IDCT as sign/magnitude on the IDCT's coef_next pull.
- Two banks (ping-pong), so the next block fills while the current one drains.

---
 rtl/m2v_scan_pkg.sv | 42 ++++
 rtl/m2v_scan_rom.sv | 14 +
 rtl/m2v_coef_scanbuf.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/m2v_scan_pkg.sv
// Shared types, constants and scan tables for the MPEG-2 coefficient scan buffer.
// Tables map scan position (index) to raster address (value) within an 8x8 block.
package m2v_scan_pkg;

    localparam int BLK_SIZE    = 64;
    localparam int MAG_MAX_POS = 2047;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    typedef enum logic {
        F_IDLE,
        F_FILL
    } fill_state_t;

    localparam logic [5:0] ZIGZAG [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [5:0] ALTERNATE [BLK_SIZE] = '{
        6'd0,  6'd8,  6'd16, 6'd24, 6'd1,  6'd9,  6'd2,  6'd10,
        6'd17, 6'd25, 6'd32, 6'd40, 6'd48, 6'd56, 6'd57, 6'd49,
        6'd41, 6'd33, 6'd26, 6'd18, 6'd3,  6'd11, 6'd4,  6'd12,
        6'd19, 6'd27, 6'd34, 6'd42, 6'd50, 6'd58, 6'd35, 6'd43,
        6'd51, 6'd59, 6'd20, 6'd28, 6'd5,  6'd13, 6'd6,  6'd14,
        6'd21, 6'd29, 6'd36, 6'd44, 6'd52, 6'd60, 6'd37, 6'd45,
        6'd53, 6'd61, 6'd22, 6'd30, 6'd7,  6'd15, 6'd23, 6'd31,
        6'd38, 6'd46, 6'd54, 6'd62, 6'd39, 6'd47, 6'd55, 6'd63
    };

endpackage

// File: rtl/m2v_scan_rom.sv
// Combinational scan-position to raster-address lookup, zigzag or alternate scan.
module m2v_scan_rom
    import m2v_scan_pkg::*;
(
    input  logic       alt_scan,
    input  logic [5:0] scan_pos,
    output logic [5:0] raster_addr
);

    always_comb begin
        raster_addr = alt_scan ? ALTERNATE[scan_pos] : ZIGZAG[scan_pos];
    end

endmodule

// File: rtl/m2v_coef_scanbuf.sv
// Ping-pong coefficient buffer between VLD/IQ and IDCT: places run/level events in
// raster order, then serves them as sign/magnitude on the IDCT's coef_next pull.
//
// state   | meaning
// F_IDLE  | no block being filled; blk_begin accepted when the fill bank is EMPTY
// F_FILL  | accepting run/level beats into the fill-pointer bank until rl_last
module m2v_coef_scanbuf
    import m2v_scan_pkg::*;
#(
    parameter int MAG_W = 12,
    parameter int LVL_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softreset,
    output logic             fill_ready,
    input  logic             blk_begin,
    input  logic             alt_scan,
    input  logic             rl_valid,
    output logic             rl_ready,
    input  logic [5:0]       rl_run,
    input  logic [LVL_W-1:0] rl_level,
    input  logic             rl_last,
    output logic             bank_full,
    input  logic             rd_start,
    input  logic             coef_next,
    output logic             coef_sign,
    output logic [MAG_W-1:0] coef_data,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam int WORD_W      = MAG_W + 1;
    localparam int MAG_MAX_NEG = MAG_MAX_POS + 1;
    localparam logic [LVL_W:0] LIM_POS = MAG_MAX_POS[LVL_W:0];
    localparam logic [LVL_W:0] LIM_NEG = MAG_MAX_NEG[LVL_W:0];

    fill_state_t         fill_st;
    fill_state_t         fill_st_nxt;
    bank_state_t         bank_st [2];
    logic                fill_ptr;
    logic                drain_ptr;
    logic [6:0]          pos;
    logic                alt_q;
    logic [BLK_SIZE-1:0] vmask [2];
    logic [WORD_W-1:0]   mem [2*BLK_SIZE];
    logic [5:0]          raddr;

    logic                blk_go;
    logic                beat_acc;
    logic [6:0]          p_sum;
    logic                in_range;
    logic                pos64_legal;
    logic [5:0]          wr_raster;
    logic                lvl_neg;
    logic [LVL_W:0]      lvl_abs;
    logic [MAG_W-1:0]    mag_sat;
    logic [WORD_W-1:0]   wr_word;
    logic                drain_go;
    logic                drain_step;
    logic                drain_end;
    logic [5:0]          rd_addr;
    logic [WORD_W-1:0]   rd_word;

    // Handshakes are decided from registered state only.
    assign fill_ready = (fill_st == F_IDLE) && (bank_st[fill_ptr] == EMPTY);
    assign rl_ready   = (fill_st == F_FILL);
    assign bank_full  = (bank_st[drain_ptr] == FULL);

    assign blk_go      = blk_begin & fill_ready;
    assign beat_acc    = rl_valid & rl_ready;
    assign p_sum       = pos + {1'b0, rl_run};
    assign in_range    = ~p_sum[6];
    assign pos64_legal = rl_last && (rl_run == 6'd0) && (pos == 7'd64);

    assign drain_go   = rd_start & bank_full;
    assign drain_step = coef_next & (bank_st[drain_ptr] == DRAINING);
    assign drain_end  = drain_step & (raddr == 6'd63);

    m2v_scan_rom u_scan_rom (
        .alt_scan    (alt_q),
        .scan_pos    (p_sum[5:0]),
        .raster_addr (wr_raster)
    );

    // Sign/magnitude saturation: negatives clip at 2048, positives at 2047.
    always_comb begin
        lvl_neg = rl_level[LVL_W-1];
        lvl_abs = lvl_neg ? ('0 - {1'b1, rl_level}) : {1'b0, rl_level};
        mag_sat = lvl_abs[MAG_W-1:0];
        if (lvl_neg) begin
            if (lvl_abs > LIM_NEG) mag_sat = LIM_NEG[MAG_W-1:0];
        end else begin
            if (lvl_abs > LIM_POS) mag_sat = LIM_POS[MAG_W-1:0];
        end
        wr_word = {lvl_neg, mag_sat};
    end

    always_comb begin
        rd_addr = drain_go ? 6'd0 : (raddr + 6'd1);
        rd_word = vmask[drain_ptr][rd_addr] ? mem[{drain_ptr, rd_addr}] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_st <= F_IDLE;
        end else if (softreset) begin
            fill_st <= F_IDLE;
        end else begin
            fill_st <= fill_st_nxt;
        end
    end

    always_comb begin
        fill_st_nxt = fill_st;
        case (fill_st)
            F_IDLE:  if (blk_go) fill_st_nxt = F_FILL;
            F_FILL:  if (beat_acc && rl_last) fill_st_nxt = F_IDLE;
            default: fill_st_nxt = F_IDLE;
        endcase
    end

    // Bank storage has no reset; the valid masks decide what reads back as nonzero.
    always_ff @(posedge clk) begin
        if (beat_acc && in_range) mem[{fill_ptr, wr_raster}] <= wr_word;
    end

    // Fill and drain sides always touch different banks, so both may update here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            vmask[0]   <= '0;
            vmask[1]   <= '0;
            fill_ptr   <= 1'b0;
            drain_ptr  <= 1'b0;
            pos        <= 7'd0;
            alt_q      <= 1'b0;
        end else if (softreset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            vmask[0]   <= '0;
            vmask[1]   <= '0;
            fill_ptr   <= 1'b0;
            drain_ptr  <= 1'b0;
            pos        <= 7'd0;
            alt_q      <= 1'b0;
        end else begin
            if (blk_go) begin
                pos               <= 7'd0;
                alt_q             <= alt_scan;
                bank_st[fill_ptr] <= FILLING;
            end
            if (beat_acc) begin
                if (in_range) begin
                    vmask[fill_ptr][wr_raster] <= 1'b1;
                    pos                        <= p_sum + 7'd1;
                end
                if (rl_last) begin
                    bank_st[fill_ptr] <= FULL;
                    fill_ptr          <= ~fill_ptr;
                end
            end
            if (drain_go) begin
                bank_st[drain_ptr] <= DRAINING;
            end else if (drain_end) begin
                vmask[drain_ptr]   <= '0;
                bank_st[drain_ptr] <= EMPTY;
                drain_ptr          <= ~drain_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr     <= 6'd0;
            coef_sign <= 1'b0;
            coef_data <= '0;
        end else if (softreset) begin
            raddr     <= 6'd0;
            coef_sign <= 1'b0;
            coef_data <= '0;
        end else if (drain_go) begin
            raddr                  <= 6'd0;
            {coef_sign, coef_data} <= rd_word;
        end else if (drain_step) begin
            if (drain_end) begin
                coef_sign <= 1'b0;
                coef_data <= '0;
            end else begin
                raddr                  <= raddr + 6'd1;
                {coef_sign, coef_data} <= rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (softreset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (beat_acc && !in_range && !pos64_legal) ovf_err <= 1'b1;
            if (rd_start && !bank_full) udf_err <= 1'b1;
        end
    end

endmodule
